// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the core's memory stage.
//   - stage command encodings (LW/ST/JMP/OTHER)
//   - access size encodings (SZ_B/SZ_H/SZ_W; 2'b11 is treated as word)
//   - lsu_state_t: load/store bus controller state enum
//   - is_mem_cmd(): true for load or store commands
package cpu_pkg;

  localparam logic [1:0] LW_CMD    = 2'b11;
  localparam logic [1:0] ST_CMD    = 2'b10;
  localparam logic [1:0] JMP_CMD   = 2'b01;
  localparam logic [1:0] OTHER_CMD = 2'b00;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    DONE  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } lsu_state_t;

  // Loads and stores are the only commands with bit 1 set.
  function automatic logic is_mem_cmd(input logic [1:0] cmd);
    return cmd[1];
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// lsu_bus_ctrl_if: data-memory request/acknowledge bus.
//   req_o    bus request (master -> slave)
//   we_o     write enable
//   addr_o   word-aligned address
//   wdata_o  lane-replicated store data
//   be_o     byte enables
//   ack_i    acknowledge (slave -> master)
//   rdata_i  read data, valid with ack_i
// Modports: master (load/store unit), slave (memory).
interface lsu_bus_ctrl_if;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic        ack_i;
  logic [31:0] rdata_i;

  modport master (
    output req_o, we_o, addr_o, wdata_o, be_o,
    input  ack_i, rdata_i
  );

  modport slave (
    input  req_o, we_o, addr_o, wdata_o, be_o,
    output ack_i, rdata_i
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Request side (from the M-stage command):
//   req_off_i, req_size_i, req_wdata_i -> be_o, wdata_o, misalign_o
// Response side (from the latched access):
//   rsp_off_i, rsp_size_i, rsp_sign_i, rsp_rdata_i -> rdata_o
module lsu_align
  import cpu_pkg::*;
(
  input  logic [1:0]  req_off_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  logic [1:0]  rsp_off_i,
  input  logic [1:0]  rsp_size_i,
  input  logic        rsp_sign_i,
  input  logic [31:0] rsp_rdata_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte enables, store-lane replication and alignment check.
  // Size 2'b11 falls into the word branch.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = req_wdata_i;
    misalign_o = 1'b0;
    case (req_size_i)
      SZ_B: begin
        be_o    = 4'b0001 << req_off_i;
        wdata_o = {4{req_wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o       = req_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{req_wdata_i[15:0]}};
        misalign_o = req_off_i[0];
      end
      default: begin
        misalign_o = |req_off_i;
      end
    endcase
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    case (rsp_off_i)
      2'd0:    byte_sel = rsp_rdata_i[7:0];
      2'd1:    byte_sel = rsp_rdata_i[15:8];
      2'd2:    byte_sel = rsp_rdata_i[23:16];
      default: byte_sel = rsp_rdata_i[31:24];
    endcase
    half_sel = rsp_off_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];
    case (rsp_size_i)
      SZ_B:    rdata_o = {{24{rsp_sign_i & byte_sel[7]}}, byte_sel};
      SZ_H:    rdata_o = {{16{rsp_sign_i & half_sel[15]}}, half_sel};
      default: rdata_o = rsp_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: memory-stage load/store bus controller.
// Turns M-stage load/store commands into a req/ack transaction on the
// data-memory bus and produces the pipeline hold signals.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cmd_inM           11 load, 10 store, 01 jump, 00 other
//   addr_inM          effective address
//   wdata_inM         store data, right-justified
//   size_inM          00 byte, 01 half, 10/11 word
//   sign_inM          sign-extend load
//   flush_in          M-stage flush
//   bus               lsu_bus_ctrl_if.master data-memory bus
//   ack_o             0 while an access is pending (combinational in IDLE)
//   stall_n_o         0 while a fault is held
//   rdata_o           extended load result, held until the next load completes
//   misalign_o        misaligned-access fault
//   timeout_o         bus timeout fault (LSU_TIMEOUT_EN only)
// Optional feature: define LSU_TIMEOUT_EN to add the TIMEOUT_CYC parameter,
// the REQ/DRAIN watchdog counter and the timeout_o port.
module lsu_bus_ctrl
  import cpu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYC = 255
)
`endif
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           cmd_inM,
  input  logic [31:0]          addr_inM,
  input  logic [31:0]          wdata_inM,
  input  logic [1:0]           size_inM,
  input  logic                 sign_inM,
  input  logic                 flush_in,
  lsu_bus_ctrl_if.master       bus,
  output logic                 ack_o,
  output logic                 stall_n_o,
  output logic [31:0]          rdata_o,
`ifdef LSU_TIMEOUT_EN
  output logic                 timeout_o,
`endif
  output logic                 misalign_o
);

  lsu_state_t  state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [31:0] rdata_q;
  logic        misalign_q;
  logic        stall_n_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        misalign_d;
  logic [31:0] load_d;
  logic        start_d;

`ifdef LSU_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q;
  logic        timeout_q;
  logic        tmo_hit_d;

  // Fires on the TIMEOUT_CYC-th bus cycle without an acknowledge.
  assign tmo_hit_d = !bus.ack_i && (tmo_cnt_q == 8'(TIMEOUT_CYC - 1));
  assign timeout_o = timeout_q;
`endif

  // A flush in the same cycle suppresses a new command.
  assign start_d = is_mem_cmd(cmd_inM) && !flush_in;

  lsu_align u_align (
    .req_off_i   (addr_inM[1:0]),
    .req_size_i  (size_inM),
    .req_wdata_i (wdata_inM),
    .be_o        (be_d),
    .wdata_o     (wdata_d),
    .misalign_o  (misalign_d),
    .rsp_off_i   (off_q),
    .rsp_size_i  (size_q),
    .rsp_sign_i  (sign_q),
    .rsp_rdata_i (bus.rdata_i),
    .rdata_o     (load_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      off_q      <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      stall_n_q  <= 1'b1;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_d) begin
            if (misalign_d) begin
              state_q    <= ERR;
              misalign_q <= 1'b1;
              stall_n_q  <= 1'b0;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
              we_q    <= (cmd_inM == ST_CMD);
              addr_q  <= {addr_inM[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              off_q   <= addr_inM[1:0];
              size_q  <= size_inM;
              sign_q  <= sign_inM;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (bus.ack_i) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) begin
              rdata_q <= load_d;
            end
`ifdef LSU_TIMEOUT_EN
          end else if (tmo_hit_d) begin
            req_q     <= 1'b0;
            state_q   <= ERR;
            timeout_q <= 1'b1;
            stall_n_q <= 1'b0;
`endif
          end else if (flush_in) begin
            // Keep the request up until the bus answers.
            state_q <= DRAIN;
          end
        end
        DONE: begin
          // The command is still on cmd_inM here; it must not be reissued.
          state_q <= IDLE;
        end
        DRAIN: begin
          if (bus.ack_i) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
`ifdef LSU_TIMEOUT_EN
          end else if (tmo_hit_d) begin
            req_q     <= 1'b0;
            state_q   <= ERR;
            timeout_q <= 1'b1;
            stall_n_q <= 1'b0;
`endif
          end
        end
        ERR: begin
          if (flush_in) begin
            state_q    <= IDLE;
            misalign_q <= 1'b0;
            stall_n_q  <= 1'b1;
`ifdef LSU_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
`ifdef LSU_TIMEOUT_EN
      if ((state_q == REQ) || (state_q == DRAIN)) begin
        if (bus.ack_i || tmo_hit_d) begin
          tmo_cnt_q <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
      end
`endif
    end
  end

  // ack_o must fall in the issue cycle itself so the pipeline freezes
  // without a bubble; everywhere else it follows the state.
  always_comb begin
    case (state_q)
      IDLE:    ack_o = !start_d;
      REQ:     ack_o = 1'b0;
      default: ack_o = 1'b1;
    endcase
  end

  assign bus.req_o   = req_q;
  assign bus.we_o    = we_q;
  assign bus.addr_o  = addr_q;
  assign bus.wdata_o = wdata_q;
  assign bus.be_o    = be_q;
  assign stall_n_o   = stall_n_q;
  assign rdata_o     = rdata_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed and randomized bench for lsu_bus_ctrl.
// Expected values come from an arithmetic model of the lane/extension rules
// and a per-transaction cycle script. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_lsu_bus_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd_inM;
  logic [31:0] addr_inM;
  logic [31:0] wdata_inM;
  logic [1:0]  size_inM;
  logic        sign_inM;
  logic        flush_in;
  logic        ack_o;
  logic        stall_n_o;
  logic [31:0] rdata_o;
  logic        misalign_o;
`ifdef LSU_TIMEOUT_EN
  logic        timeout_o;
`endif

  lsu_bus_ctrl_if bus ();

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  lsu_bus_ctrl #(.TIMEOUT_CYC(4)) dut (
`else
  lsu_bus_ctrl dut (
`endif
    .clk        (clk),
    .reset      (reset),
    .cmd_inM    (cmd_inM),
    .addr_inM   (addr_inM),
    .wdata_inM  (wdata_inM),
    .size_inM   (size_inM),
    .sign_inM   (sign_inM),
    .flush_in   (flush_in),
    .bus        (bus),
    .ack_o      (ack_o),
    .stall_n_o  (stall_n_o),
    .rdata_o    (rdata_o),
`ifdef LSU_TIMEOUT_EN
    .timeout_o  (timeout_o),
`endif
    .misalign_o (misalign_o)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int m_width(input logic [1:0] sz);
    if (sz == SZ_B) return 8;
    if (sz == SZ_H) return 16;
    return 32;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] off);
    return (int'(off) % (m_width(sz) / 8)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    int nbytes = m_width(sz) / 8;
    return 4'(((1 << nbytes) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == SZ_B) return {24'b0, wd[7:0]} * 32'h01010101;
    if (sz == SZ_H) return {16'b0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic sgn,
                                       input logic [1:0] off, input logic [31:0] rd);
    int w = m_width(sz);
    logic [63:0] v = {32'b0, rd} >> (8 * int'(off));
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    v = v & mask;
    if (sgn && v[w-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // One load/store from an idle controller. flush_at >= 0 flushes in that
  // REQ wait cycle; drain is the number of extra DRAIN cycles before ack_i.
  task automatic access(input logic [1:0] cmd, input logic [31:0] addr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] wd, input int waits,
                        input int flush_at, input int drain, input logic [31:0] rd);
    logic [1:0] off = addr[1:0];
    logic st = (cmd == ST_CMD);
    bit flushed = 0;
    cmd_inM = cmd; addr_inM = addr; size_inM = sz; sign_inM = sgn; wdata_inM = wd; flush_in = 0;
    #1 check("ack_issue", ack_o, 0);
    if (m_mis(sz, off)) begin
      @(negedge clk);
      check("err_req", bus.req_o, 0);
      check("err_misalign", misalign_o, 1);
      check("err_stall_n", stall_n_o, 0);
      check("err_ack", ack_o, 1);
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        check("err_hold_misalign", misalign_o, 1);
        check("err_hold_req", bus.req_o, 0);
      end
      flush_in = 1; cmd_inM = OTHER_CMD;
      @(negedge clk);
      flush_in = 0;
      check("err_exit_misalign", misalign_o, 0);
      check("err_exit_stall_n", stall_n_o, 1);
      check("err_exit_ack", ack_o, 1);
      check("err_exit_req", bus.req_o, 0);
      $display("txn misaligned cmd=%0d addr=%h size=%0d", cmd, addr, sz);
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      check("req_req", bus.req_o, 1);
      check("req_ack", ack_o, 0);
      check("req_addr", bus.addr_o, {addr[31:2], 2'b00});
      check("req_be", {28'b0, bus.be_o}, {28'b0, m_be(sz, off)});
      check("req_we", bus.we_o, st);
      if (st) check("req_wdata", bus.wdata_o, m_wd(sz, wd));
      if (w == flush_at) begin
        flush_in = 1;
        flushed = 1;
        break;
      end
      if (w == waits) begin
        bus.ack_i = 1; bus.rdata_i = rd;
      end
    end
    if (flushed) begin
      for (int d = 0; d <= drain; d++) begin
        @(negedge clk);
        flush_in = 0; cmd_inM = OTHER_CMD;
        check("drain_req", bus.req_o, 1);
        check("drain_ack", ack_o, 1);
        if (d == drain) begin
          bus.ack_i = 1; bus.rdata_i = rd;
        end
      end
      @(negedge clk);
      bus.ack_i = 0; bus.rdata_i = $urandom;
      #1;
      check("drain_done_req", bus.req_o, 0);
      check("drain_done_ack", ack_o, 1);
      check("drain_rdata_kept", rdata_o, exp_rd);
      $display("txn flushed cmd=%0d addr=%h size=%0d drain=%0d rdata_o=%h", cmd, addr, sz, drain, rdata_o);
      return;
    end
    @(negedge clk);
    bus.ack_i = 0; bus.rdata_i = $urandom;
    if (!st) exp_rd = m_ld(sz, sgn, off, rd);
    #1;
    check("done_req", bus.req_o, 0);
    check("done_ack", ack_o, 1);
    check("done_rdata", rdata_o, exp_rd);
    cmd_inM = OTHER_CMD;
    @(negedge clk);
    check("idle_no_reissue", bus.req_o, 0);
    check("idle_ack", ack_o, 1);
    $display("txn %s addr=%h size=%0d sign=%0d waits=%0d rdata_o=%h", st ? "store" : "load",
             addr, sz, sgn, waits, rdata_o);
  endtask

  initial begin
    reset = 1; cmd_inM = OTHER_CMD; addr_inM = 0; wdata_inM = 0; size_inM = SZ_W;
    sign_inM = 0; flush_in = 0; bus.ack_i = 0; bus.rdata_i = 0;
    repeat (2) @(negedge clk);
    check("rst_req", bus.req_o, 0);
    check("rst_we", bus.we_o, 0);
    check("rst_be", {28'b0, bus.be_o}, 0);
    check("rst_addr", bus.addr_o, 0);
    check("rst_wdata", bus.wdata_o, 0);
    check("rst_ack", ack_o, 1);
    check("rst_stall_n", stall_n_o, 1);
    check("rst_rdata", rdata_o, 0);
    check("rst_misalign", misalign_o, 0);
    reset = 0;
    @(negedge clk);

    // Directed steps.
    access(LW_CMD, 32'h100, SZ_W, 0, 0, 0, -1, 0, 32'hDEADBEEF);
    check("word_load_value", rdata_o, 32'hDEADBEEF);
    access(LW_CMD, 32'h103, SZ_B, 1, 0, 1, -1, 0, 32'h80AABBCC);
    check("sbyte_value", rdata_o, 32'hFFFFFF80);
    access(LW_CMD, 32'h103, SZ_B, 0, 0, 0, -1, 0, 32'h80AABBCC);
    check("ubyte_value", rdata_o, 32'h00000080);
    access(ST_CMD, 32'h202, SZ_H, 0, 32'h1234, 4, -1, 0, 32'h0);
    check("store_keeps_rdata", rdata_o, 32'h00000080);
    access(LW_CMD, 32'h101, SZ_W, 0, 0, 3, -1, 0, 32'h0);
    access(LW_CMD, 32'h300, SZ_W, 0, 0, 2, 0, 2, 32'h55667788);

    // Flush on the same cycle as a new command: suppressed.
    cmd_inM = LW_CMD; addr_inM = 32'h400; size_inM = SZ_W; flush_in = 1;
    #1 check("flush_cmd_ack", ack_o, 1);
    @(negedge clk);
    flush_in = 0; cmd_inM = OTHER_CMD;
    check("flush_cmd_req", bus.req_o, 0);
    check("flush_cmd_misalign", misalign_o, 0);
    $display("txn suppressed-by-flush addr=400");

    // Jump command is not a memory access.
    cmd_inM = JMP_CMD; addr_inM = 32'h401;
    #1 check("jmp_ack", ack_o, 1);
    @(negedge clk);
    cmd_inM = OTHER_CMD;
    check("jmp_req", bus.req_o, 0);
    check("jmp_misalign", misalign_o, 0);
    $display("txn jump addr=401");

    // Reset while in REQ, then a late ack_i in IDLE.
    cmd_inM = LW_CMD; addr_inM = 32'h40; size_inM = SZ_W;
    @(negedge clk);
    check("rstreq_req_before", bus.req_o, 1);
    reset = 1;
    @(negedge clk);
    reset = 0; cmd_inM = OTHER_CMD; exp_rd = '0;
    check("rstreq_req_after", bus.req_o, 0);
    check("rstreq_rdata", rdata_o, 0);
    bus.ack_i = 1; bus.rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    bus.ack_i = 0;
    #1;
    check("late_ack_req", bus.req_o, 0);
    check("late_ack_ack", ack_o, 1);
    check("late_ack_rdata", rdata_o, 0);
    $display("txn reset-in-req addr=40");

`ifdef LSU_TIMEOUT_EN
    cmd_inM = LW_CMD; addr_inM = 32'h500; size_inM = SZ_W;
    #1 check("tmo_issue_ack", ack_o, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_inM = OTHER_CMD;
      check("tmo_req_high", bus.req_o, 1);
    end
    @(negedge clk);
    check("tmo_req_drop", bus.req_o, 0);
    check("tmo_timeout", timeout_o, 1);
    check("tmo_stall_n", stall_n_o, 0);
    check("tmo_misalign", misalign_o, 0);
    flush_in = 1;
    @(negedge clk);
    flush_in = 0;
    check("tmo_exit_timeout", timeout_o, 0);
    check("tmo_exit_stall_n", stall_n_o, 1);
    $display("txn timeout addr=500");
`endif

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] c = 2'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      logic [1:0] s = 2'($urandom_range(0, 3));
      int waits = $urandom_range(0, 3);
      int fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, waits) : -1;
      if ($urandom_range(0, 3) != 0) a[1:0] = (s == SZ_B) ? a[1:0] : (s == SZ_H) ? {a[1], 1'b0} : 2'b00;
      if (is_mem_cmd(c)) begin
        access(c, a, s, 1'($urandom), $urandom, waits, fa, $urandom_range(0, 2), $urandom);
      end else begin
        cmd_inM = c; addr_inM = a;
        #1 check("rnd_nonmem_ack", ack_o, 1);
        @(negedge clk);
        cmd_inM = OTHER_CMD;
        check("rnd_nonmem_req", bus.req_o, 0);
        $display("txn nonmem cmd=%0d addr=%h", c, a);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Memory-stage load/store bus controller for the 5-stage core.
- Turns M-stage load/store commands into a request/acknowledge transaction on the data-memory bus.
- Produces the pipeline-hold signals consumed by hazard_unit: ack (0 = access in flight) and stall_n (0 = fault hold).
- Returns aligned, sign/zero-extended load data to the W-stage mux.

Parameters:
- TIMEOUT_CYC, 255, max cycles to wait for ack_i (only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  core clock
- reset  in  1  sync reset
- cmd_inM  in  2  stage command: 11 load, 10 store, 01 jump, 00 other
- addr_inM  in  32  effective address
- wdata_inM  in  32  store data, right-justified
- size_inM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- sign_inM  in  1  1 = sign-extend load
- flush_in  in  1  M-stage flush from hazard_unit
- req_o  out  1  bus request
- we_o  out  1  bus write enable
- addr_o  out  32  word-aligned bus address, {addr[31:2],2'b00}
- wdata_o  out  32  lane-replicated store data
- be_o  out  4  byte enables
- ack_i  in  1  bus acknowledge
- rdata_i  in  32  bus read data, valid with ack_i
- ack_o  out  1  0 while access pending; to hazard_unit ack_in
- stall_n_o  out  1  0 while fault held; to hazard_unit stal_in
- rdata_o  out  32  extended load result
- misalign_o  out  1  misaligned-access fault flag

Behaviour:
- Reset is reset: synchronous, active-high.
- Reset values:
  - state IDLE
  - req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0
  - ack_o=1, stall_n_o=1, rdata_o=0, misalign_o=0
- States: IDLE, REQ, DONE, DRAIN, ERR.
- IDLE, cmd_inM is load/store and flush_in=0:
  - ack_o=0 combinationally in the same cycle, so the pipeline freezes.
  - Aligned access: latch addr/be/wdata/we/size/sign; go to REQ.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): go to ERR; no bus request is issued.
- IDLE, otherwise: ack_o=1.
- REQ:
  - req_o=1; addr_o, we_o, be_o, wdata_o held stable; ack_o=0.
  - On ack_i=1: drop req_o next cycle; capture and extend rdata_i; go to DONE.
  - flush_in=1 without ack_i: go to DRAIN. The bus is never abandoned.
- DONE: one cycle, ack_o=1, rdata_o valid; next state IDLE. cmd_inM is still present in DONE and is not reissued.
- DRAIN: req_o=1 until ack_i; the response is discarded; ack_o=1; then IDLE.
- ERR:
  - misalign_o=1, stall_n_o=0, ack_o=1.
  - Exits to IDLE only on flush_in=1; misalign_o and stall_n_o clear the same cycle.
- Minimum load/store latency: 3 cycles (IDLE issue, REQ with ack_i, DONE). Each extra cycle of ack_i wait adds 1.
- Byte enables:
  - byte: be = 1 << addr[1:0]
  - half: be = addr[1] ? 1100 : 0011
  - word: be = 1111
- Store data lanes: byte replicated x4, half replicated x2.
- Load extraction: select the byte/half by addr[1:0], then sign- or zero-extend to 32 bits. rdata_o holds its value until the next completed load.
- ack_i outside REQ/DRAIN is ignored.
- Reset mid-transaction:
  - req_o drops the next cycle; state goes to IDLE.
  - Any late ack_i is ignored by the IDLE rule.
- flush_in in the same cycle as a new command in IDLE: the command is suppressed.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With it defined:
  - An 8-bit counter runs in REQ/DRAIN and clears on ack_i.
  - Reaching TIMEOUT_CYC drops req_o and enters ERR with misalign_o=0 and the extra output timeout_o=1.
  - ERR exits on flush_in, as for a misalign fault.
- Without it: no counter and no timeout_o port; REQ/DRAIN wait indefinitely.

Decomposition:
- Shared package cpu_pkg:
  - cmd encodings LW_CMD=2'b11, ST_CMD=2'b10, JMP_CMD=2'b01, OTHER_CMD=2'b00
  - size encodings SZ_B, SZ_H, SZ_W
  - state enum lsu_state_t
- One natural sub-module: lsu_align, purely combinational. Computes be, lane-replicated wdata, the misalign flag, and load extraction/extension.

Test Plan:
- Word load at 0x100, ack_i one cycle after req_o, rdata_i=0xDEADBEEF -> be_o=1111; ack_o low 2 cycles; DONE rdata_o=0xDEADBEEF.
- Signed byte load at 0x103, rdata_i=0x80AABBCC -> be_o=1000; rdata_o=0xFFFFFF80. Unsigned variant -> 0x00000080.
- Half store 0x1234 at 0x202 -> addr_o=0x200, be_o=1100, wdata_o=0x12341234, we_o=1. req_o held through 4 wait cycles until ack_i.
- Word load at 0x101 -> req_o never asserts; misalign_o=1, stall_n_o=0 until flush_in; then IDLE with ack_o=1.
- flush_in during REQ, ack_i 3 cycles later -> DRAIN; rdata_o unchanged; ack_o=1 during DRAIN; IDLE after ack_i. Reset in REQ -> req_o=0 next cycle.
- With LSU_TIMEOUT_EN and TIMEOUT_CYC=4, no ack_i -> req_o drops after 4 cycles; timeout_o=1, stall_n_o=0.
